// File: rtl/int_to_float_pkg.sv
// int_to_float_pkg
//   Shared definitions for the int32 -> IEEE-754 single converter:
//   FP32 field widths, the exponent bias, the packed fp32_t layout and a
//   two's-complement magnitude helper.
package int_to_float_pkg;

    localparam int FP32_BIAS   = 127;
    localparam int FP32_MANT_W = 23;
    localparam int FP32_EXP_W  = 8;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_MANT_W-1:0] mant;
    } fp32_t;

    // Magnitude of a two's-complement int32. -2^31 maps to 0x80000000,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] a);
        return a[31] ? (~a + 32'd1) : a;
    endfunction

endpackage

// File: rtl/i2f_lzc.sv
// i2f_lzc
//   32-bit leading-one encoder. Split into four byte encoders plus a
//   byte-select so the priority chain stays short.
// Ports:
//   a     in  32 : value to scan
//   e     out 5  : index of the highest set bit (0 when a == 0)
//   zero  out 1  : a == 0
module i2f_lzc (
    input  logic [31:0] a,
    output logic [4:0]  e,
    output logic        zero
);

    logic [3:0]      byte_nz;
    logic [3:0][2:0] byte_pos;
    logic [1:0]      hb;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_byte
            logic [7:0] b;
            logic [2:0] pos;
            assign b = a[8*g +: 8];
            assign byte_nz[g] = |b;
            always_comb begin
                pos = '0;
                for (int i = 0; i < 8; i++)
                    if (b[i]) pos = 3'(i);
            end
            assign byte_pos[g] = pos;
        end
    endgenerate

    // Highest non-zero byte wins; its local position fills the low bits.
    always_comb begin
        hb = '0;
        for (int i = 0; i < 4; i++)
            if (byte_nz[i]) hb = 2'(i);
    end

    assign e    = {hb, byte_pos[hb]};
    assign zero = ~|byte_nz;

endmodule

// File: rtl/int_to_float_arb.sv
// int_to_float_arb
//   One shared int32 -> fp32 converter serving N_REQ AXI-Stream requesters.
//   A round-robin arbiter grants one valid requester per cycle; the word
//   passes a 2-stage pipeline (magnitude + leading-one, then pack) and
//   leaves tagged with its requester index. Mantissa is truncated.
// Ports:
//   aclk, rst                        clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready       N_REQ int32 requesters (lane k = bits 32k+:32)
//   m_axis_tdata/tid/tvalid/tready   fp32 result stream with requester tag
//   conv_count                       completed output handshakes (wrapping)
module int_to_float_arb
    import int_to_float_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic [32*N_REQ-1:0]   s_axis_tdata,
    input  logic [N_REQ-1:0]      s_axis_tvalid,
    output logic [N_REQ-1:0]      s_axis_tready,
    output logic [31:0]           m_axis_tdata,
    output logic [ID_W-1:0]       m_axis_tid,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [31:0]           conv_count
);

    localparam int STAGES = 2;

    logic              en;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic              any_req;
    logic              grant_hs;
    logic [31:0]       sel_data;
    logic [31:0]       sel_mag;
    logic [4:0]        sel_e;
    logic              sel_zero;

    // vld_pipe[1] is stage 1, vld_pipe[2] mirrors the output register.
    logic [STAGES:1]   vld_pipe;
    logic              s1_sign;
    logic [31:0]       s1_mag;
    logic [4:0]        s1_e;
    logic              s1_zero;
    logic [ID_W-1:0]   s1_id;

    fp32_t             res;
    logic [31:0]       norm;

    // Whole pipeline moves together; an empty output never blocks.
    assign en = !m_axis_tvalid || m_axis_tready;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!any_req && s_axis_tvalid[idx]) begin
                any_req   = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    assign grant_hs      = en && any_req && !rst;
    assign s_axis_tready = grant_hs ? (N_REQ'(1) << grant_idx) : '0;

    assign sel_data = s_axis_tdata[grant_idx*32 +: 32];
    assign sel_mag  = abs32(sel_data);

    i2f_lzc u_lzc (
        .a    (sel_mag),
        .e    (sel_e),
        .zero (sel_zero)
    );

    // Arbiter pointer and stage 1.
    always_ff @(posedge aclk) begin
        if (rst) begin
            rr_ptr      <= '0;
            vld_pipe[1] <= 1'b0;
            s1_sign     <= 1'b0;
            s1_mag      <= '0;
            s1_e        <= '0;
            s1_zero     <= 1'b0;
            s1_id       <= '0;
        end else if (en) begin
            vld_pipe[1] <= any_req;
            if (any_req) begin
                rr_ptr  <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                s1_sign <= sel_data[31];
                s1_mag  <= sel_mag;
                s1_e    <= sel_e;
                s1_zero <= sel_zero;
                s1_id   <= grant_idx;
            end
        end
    end

    // Left-justify the leading one at bit 31; the 23 bits below it are the
    // mantissa and everything further down is dropped (truncation).
    assign norm = s1_mag << (5'd31 - s1_e);

    always_comb begin
        res.sign = s1_sign;
        res.exp  = FP32_EXP_W'(FP32_BIAS) + FP32_EXP_W'(s1_e);
        res.mant = norm[30 -: FP32_MANT_W];
        if (s1_zero) res = '0;   // zero is +0 regardless of input sign
    end

    // Stage 2 = output register.
    always_ff @(posedge aclk) begin
        if (rst) begin
            vld_pipe[2]  <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tid   <= '0;
        end else if (en) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                m_axis_tdata <= res;
                m_axis_tid   <= s1_id;
            end
        end
    end

    assign m_axis_tvalid = vld_pipe[2];

    always_ff @(posedge aclk) begin
        if (rst)
            conv_count <= '0;
        else if (m_axis_tvalid && m_axis_tready)
            conv_count <= conv_count + 32'd1;
    end

endmodule

// File: tb/tb_int_to_float_arb.sv
module tb_int_to_float_arb;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic              aclk = 1'b0;
    logic              rst;
    logic [32*N-1:0]   s_tdata;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [31:0]       m_tdata;
    logic [ID_W-1:0]   m_tid;
    logic              m_tvalid;
    logic              m_tready;
    logic [31:0]       conv_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          in_id[$];
    int          in_cyc[$];
    logic [31:0] out_data[$];
    int          out_id[$];
    int          out_cyc[$];

    int_to_float_arb #(.N_REQ(N)) dut (
        .aclk          (aclk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tid    (m_tid),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .conv_count    (conv_count)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Handshake logger for the directed tests.
    always @(negedge aclk) begin
        if (!rst) begin
            for (int k = 0; k < N; k++)
                if (s_tvalid[k] && s_tready[k]) begin
                    in_id.push_back(k);
                    in_cyc.push_back(cyc);
                end
            if (m_tvalid && m_tready) begin
                out_data.push_back(m_tdata);
                out_id.push_back(int'(m_tid));
                out_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Truncating reference conversion.
    function automatic logic [31:0] ref_conv(input logic [31:0] a);
        logic [31:0] mag;
        logic [31:0] m;
        int e;
        mag = a[31] ? (32'd0 - a) : a;
        if (mag == 32'd0) return 32'd0;
        e = 31;
        while (!mag[e]) e--;
        if (e >= 23) m = (mag >> (e - 23)) & 32'h007F_FFFF;
        else         m = (mag << (23 - e)) & 32'h007F_FFFF;
        return {a[31], 8'(e + 127), m[22:0]};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_logs();
        in_id.delete(); in_cyc.delete();
        out_data.delete(); out_id.delete(); out_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; s_tvalid = '0; m_tready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1; s_tvalid = '1; s_tdata = '1; m_tready = 1'b1;
        tick(); tick();
        @(negedge aclk);
        checks += 5;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
        if (m_tdata !== 32'd0) begin failures++; $display("FAIL reset_tdata: got %h expected 00000000", m_tdata); end
        if (m_tid !== '0) begin failures++; $display("FAIL reset_tid: got %0d expected 0", m_tid); end
        if (conv_count !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", conv_count); end
        if (s_tready !== '0) begin failures++; $display("FAIL reset_tready: got %b expected 0000", s_tready); end
        tick();
        rst = 1'b0; s_tvalid = '0;
        tick();
        clear_logs();
    endtask

    task automatic test_single();
        logic [31:0] vals [5];
        logic [31:0] exps [5];
        vals = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0100_0001, 32'h8000_0000};
        exps = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4B80_0000, 32'hCF00_0000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            s_tdata[31:0] = vals[i];
            s_tvalid = 4'b0001;
            @(negedge aclk);
            checks++;
            if (s_tready !== 4'b0001) begin failures++; $display("FAIL single_tready[%0d]: got %b expected 0001", i, s_tready); end
            tick();
        end
        s_tvalid = '0;
        repeat (5) tick();
        checks++;
        if (out_data.size() != 5) begin failures++; $display("FAIL single_count_out: got %0d expected 5", out_data.size()); end
        for (int i = 0; i < 5 && i < out_data.size(); i++) begin
            checks += 3;
            if (out_data[i] !== exps[i]) begin failures++; $display("FAIL single_data[%0d]: got %h expected %h", i, out_data[i], exps[i]); end
            if (out_id[i] != 0) begin failures++; $display("FAIL single_tid[%0d]: got %0d expected 0", i, out_id[i]); end
            if (out_cyc[i] != out_cyc[0] + i) begin failures++; $display("FAIL single_b2b[%0d]: got cycle %0d expected %0d", i, out_cyc[i], out_cyc[0] + i); end
        end
        if (out_cyc.size() > 0 && in_cyc.size() > 0) begin
            checks++;
            if (out_cyc[0] - in_cyc[0] != 2) begin failures++; $display("FAIL single_latency: got %0d expected 2", out_cyc[0] - in_cyc[0]); end
        end
        @(negedge aclk);
        checks++;
        if (conv_count !== 32'd5) begin failures++; $display("FAIL single_conv_count: got %0d expected 5", conv_count); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exps [4];
        exps = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        do_reset();
        for (int k = 0; k < N; k++) s_tdata[32*k +: 32] = 32'(k + 1);
        s_tvalid = '1;
        repeat (8) tick();
        s_tvalid = '0;
        repeat (4) tick();
        checks += 2;
        if (in_id.size() != 8) begin failures++; $display("FAIL rr_grants: got %0d expected 8", in_id.size()); end
        if (out_id.size() != 8) begin failures++; $display("FAIL rr_outputs: got %0d expected 8", out_id.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < in_id.size()) begin
                checks++;
                if (in_id[i] != i % 4) begin failures++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, in_id[i], i % 4); end
            end
            if (i < out_id.size()) begin
                checks += 2;
                if (out_id[i] != i % 4) begin failures++; $display("FAIL rr_tid[%0d]: got %0d expected %0d", i, out_id[i], i % 4); end
                if (out_data[i] !== exps[i % 4]) begin failures++; $display("FAIL rr_data[%0d]: got %h expected %h", i, out_data[i], exps[i % 4]); end
            end
        end
    endtask

    task automatic test_rr_ptr2();
        int exp_ids [3];
        exp_ids = '{1, 3, 1};
        do_reset();
        s_tdata[63:32]  = 32'd5;
        s_tdata[127:96] = 32'hFFFF_FFFD;
        s_tvalid = 4'b0010;         // grant 1 -> rr_ptr = 2
        tick();
        s_tvalid = 4'b1010;
        tick(); tick();
        s_tvalid = '0;
        repeat (4) tick();
        checks += 2;
        if (in_id.size() != 3) begin failures++; $display("FAIL ptr2_grants: got %0d expected 3", in_id.size()); end
        if (out_id.size() != 3) begin failures++; $display("FAIL ptr2_outputs: got %0d expected 3", out_id.size()); end
        for (int i = 0; i < 3 && i < in_id.size(); i++) begin
            checks++;
            if (in_id[i] != exp_ids[i]) begin failures++; $display("FAIL ptr2_grant[%0d]: got %0d expected %0d", i, in_id[i], exp_ids[i]); end
        end
        if (out_data.size() == 3) begin
            checks += 2;
            if (out_id[1] != 3) begin failures++; $display("FAIL ptr2_tid: got %0d expected 3", out_id[1]); end
            if (out_data[1] !== 32'hC040_0000) begin failures++; $display("FAIL ptr2_data: got %h expected c0400000", out_data[1]); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        m_tready = 1'b0;
        s_tdata[95:64] = 32'd7;
        s_tvalid = 4'b0100;
        tick();
        s_tdata[95:64] = 32'hFFFF_FFF9;
        tick();
        s_tdata[95:64] = 32'd9;     // third word must not be accepted while stalled
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks += 4;
            if (m_tvalid !== 1'b1) begin failures++; $display("FAIL stall_tvalid[%0d]: got %b expected 1", i, m_tvalid); end
            if (m_tdata !== 32'h40E0_0000) begin failures++; $display("FAIL stall_tdata[%0d]: got %h expected 40e00000", i, m_tdata); end
            if (m_tid !== 2'd2) begin failures++; $display("FAIL stall_tid[%0d]: got %0d expected 2", i, m_tid); end
            if (s_tready !== '0) begin failures++; $display("FAIL stall_tready[%0d]: got %b expected 0000", i, s_tready); end
            tick();
        end
        s_tvalid = '0;
        m_tready = 1'b1;
        repeat (4) tick();
        checks += 2;
        if (in_id.size() != 2) begin failures++; $display("FAIL stall_accepted: got %0d expected 2", in_id.size()); end
        if (out_data.size() != 2) begin failures++; $display("FAIL stall_drained: got %0d expected 2", out_data.size()); end
        if (out_data.size() == 2) begin
            checks += 4;
            if (out_data[0] !== 32'h40E0_0000) begin failures++; $display("FAIL stall_out0: got %h expected 40e00000", out_data[0]); end
            if (out_data[1] !== 32'hC0E0_0000) begin failures++; $display("FAIL stall_out1: got %h expected c0e00000", out_data[1]); end
            if (out_id[1] != 2) begin failures++; $display("FAIL stall_out1_tid: got %0d expected 2", out_id[1]); end
            if (out_cyc[1] != out_cyc[0] + 1) begin failures++; $display("FAIL stall_consecutive: got %0d expected %0d", out_cyc[1], out_cyc[0] + 1); end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        s_tdata[63:32] = 32'd10;
        s_tdata[95:64] = 32'd11;
        s_tvalid = 4'b0010; tick();
        s_tvalid = 4'b0100; tick();   // rr_ptr = 3
        s_tvalid = '0;
        repeat (4) tick();
        @(negedge aclk);
        checks++;
        if (conv_count !== 32'd2) begin failures++; $display("FAIL mid_pre_count: got %0d expected 2", conv_count); end
        m_tready = 1'b0;
        s_tvalid = 4'b0100; tick();   // rr_ptr stays 3
        s_tvalid = 4'b0010; tick();   // rr_ptr = 2, both stages now full
        s_tvalid = '0;
        @(negedge aclk);
        checks++;
        if (m_tvalid !== 1'b1) begin failures++; $display("FAIL mid_full: got %b expected 1", m_tvalid); end
        #1;
        rst = 1'b1; s_tvalid = 4'b1010;
        @(negedge aclk);
        checks++;
        if (s_tready !== '0) begin failures++; $display("FAIL mid_rst_tready: got %b expected 0000", s_tready); end
        tick();
        rst = 1'b0; m_tready = 1'b1;
        @(negedge aclk);
        checks += 3;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid: got %b expected 0", m_tvalid); end
        if (conv_count !== 32'd0) begin failures++; $display("FAIL mid_count: got %0d expected 0", conv_count); end
        if (s_tready !== 4'b0010) begin failures++; $display("FAIL mid_first_grant: got %b expected 0010", s_tready); end
        tick();
        s_tvalid = '0;
        repeat (4) tick();
        @(negedge aclk);
        checks += 3;
        if (out_data.size() != 3) begin failures++; $display("FAIL mid_out_count: got %0d expected 3", out_data.size()); end
        if (conv_count !== 32'd1) begin failures++; $display("FAIL mid_post_count: got %0d expected 1", conv_count); end
        if (out_data.size() == 3 && out_data[2] !== 32'h4120_0000) begin failures++; $display("FAIL mid_post_data: got %h expected 41200000", out_data[2]); end
    endtask

    task automatic test_random();
        logic [31:0] exp_q [N][$];
        logic [31:0] specials [4];
        logic [31:0] val, expv, prev_data;
        logic [N-1:0] hs;
        logic prev_stall;
        int prev_id, sent, got, pending, cycles;
        specials = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        sent = 0; got = 0; pending = 0; cycles = 0;
        prev_stall = 1'b0; prev_data = '0; prev_id = 0;
        do_reset();
        while ((sent < 10000 || s_tvalid != '0 || pending > 0) && cycles < 60000) begin
            @(negedge aclk);
            hs = s_tvalid & s_tready;
            if ($countones(s_tready) > 1) begin
                checks++; failures++;
                $display("FAIL rand_onehot: got %b expected at most one bit", s_tready);
            end
            if (prev_stall) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_data || int'(m_tid) != prev_id) begin
                    failures++;
                    $display("FAIL rand_stable: got %b/%h/%0d expected 1/%h/%0d", m_tvalid, m_tdata, m_tid, prev_data, prev_id);
                end
            end
            for (int k = 0; k < N; k++)
                if (hs[k]) begin
                    exp_q[k].push_back(ref_conv(s_tdata[32*k +: 32]));
                    pending++;
                end
            if (m_tvalid && m_tready) begin
                checks++;
                got++;
                pending--;
                if (exp_q[m_tid].size() == 0) begin
                    failures++;
                    $display("FAIL rand_unexpected: got %h tid %0d expected nothing", m_tdata, m_tid);
                end else begin
                    expv = exp_q[m_tid].pop_front();
                    if (m_tdata !== expv) begin
                        failures++;
                        $display("FAIL rand_data tid %0d: got %h expected %h", m_tid, m_tdata, expv);
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_id    = int'(m_tid);
            tick();
            for (int k = 0; k < N; k++) begin
                if (!s_tvalid[k] || hs[k]) begin
                    if (sent < 10000 && $urandom_range(0, 1) == 1) begin
                        case ($urandom_range(0, 3))
                            0: val = $urandom;
                            1: val = 32'($urandom_range(0, 200)) - 32'd100;
                            2: begin
                                val = 32'd1 << $urandom_range(0, 31);
                                if ($urandom_range(0, 1) == 1) val = 32'd0 - val;
                            end
                            default: val = specials[$urandom_range(0, 3)];
                        endcase
                        s_tdata[32*k +: 32] = val;
                        s_tvalid[k] = 1'b1;
                        sent++;
                    end else begin
                        s_tvalid[k] = 1'b0;
                    end
                end
            end
            m_tready = ($urandom_range(0, 3) != 0);
            cycles++;
        end
        m_tready = 1'b1;
        checks += 3;
        if (cycles >= 60000) begin failures++; $display("FAIL rand_timeout: got %0d cycles expected under 60000", cycles); end
        if (got != 10000) begin failures++; $display("FAIL rand_total: got %0d expected 10000", got); end
        @(negedge aclk);
        if (conv_count !== 32'(got)) begin failures++; $display("FAIL rand_conv_count: got %0d expected %0d", conv_count, got); end
    endtask

    initial begin
        rst = 1'b1; s_tvalid = '0; s_tdata = '0; m_tready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_rr_ptr2();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
